// File: rtl/mac_tap_sequencer_pkg.sv
// Shared widths, state encoding and default latencies for the MAC tap sequencer.
// No logic; pure declarations.
// No flow control.
package mac_tap_sequencer_pkg;

    localparam int MAC_A_W     = 55;
    localparam int MAC_B_W     = 16;
    localparam int MAC_P_W     = 78;
    localparam int DEF_RD_LAT  = 1;
    localparam int DEF_MUL_LAT = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        DRAIN  = 2'd2,
        FINISH = 2'd3
    } state_t;

endpackage

// File: rtl/mac_tap_sequencer_valid_pipe.sv
// Delays a single qualifier bit (operand valid or first-tap tag) by DEPTH cycles.
// Latency DEPTH cycles; DEPTH=0 is a wire.
// No backpressure: advances every cycle.
module mac_valid_pipe #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_i,
    output logic out_o
);

    generate
        if (DEPTH == 0) begin : g_wire
            assign out_o = in_i;
        end else begin : g_pipe
            logic [DEPTH-1:0] stage_q;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    stage_q <= '0;
                end else begin
                    stage_q[0] <= in_i;
                    for (int i = 1; i < DEPTH; i++) begin
                        stage_q[i] <= stage_q[i-1];
                    end
                end
            end

            assign out_o = stage_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/mac_tap_sequencer.sv
// Sequences one p <= c + a*b datapath through an N-tap dot product from coef/sample RAMs.
// done at start_cycle + len + RD_LAT + MUL_LAT + 2 (len=0: next cycle).
// start is ignored unless IDLE; no downstream backpressure.
module mac_tap_sequencer
    import mac_tap_sequencer_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int RD_LAT  = DEF_RD_LAT,
    parameter int MUL_LAT = DEF_MUL_LAT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [ADDR_W:0]    len,
    input  logic [ADDR_W-1:0]  samp_base,
    output logic               busy,
    output logic               done,
    output logic [MAC_P_W-1:0] result,
    output logic               coef_rd_en,
    output logic [ADDR_W-1:0]  coef_addr,
    input  logic [MAC_A_W-1:0] coef_data,
    output logic               samp_rd_en,
    output logic [ADDR_W-1:0]  samp_addr,
    input  logic [MAC_B_W-1:0] samp_data,
    output logic [MAC_A_W-1:0] mac_a,
    output logic [MAC_B_W-1:0] mac_b,
    output logic [MAC_P_W-1:0] mac_c,
    input  logic [MAC_P_W-1:0] mac_p
);

    // DRAIN lasts RD_LAT+MUL_LAT+1 cycles; the tap counter is reused to time it.
    localparam logic [ADDR_W:0] DRAIN_LAST = (ADDR_W+1)'(RD_LAT + MUL_LAT);

    state_t               state_q, state_d;
    logic [ADDR_W:0]      tap_q, tap_d;
    logic [ADDR_W:0]      len_q, len_d;
    logic [ADDR_W-1:0]    base_q, base_d;
    logic [MAC_P_W-1:0]   result_q, result_d;

    logic issue;
    logic tap0;
    logic opnd_vld;
    logic first_tap;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            tap_q    <= '0;
            len_q    <= '0;
            base_q   <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            tap_q    <= tap_d;
            len_q    <= len_d;
            base_q   <= base_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        tap_d    = tap_q;
        len_d    = len_q;
        base_d   = base_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (len == '0) begin
                        state_d  = FINISH;
                        result_d = '0;
                    end else begin
                        state_d = ISSUE;
                        len_d   = len;
                        base_d  = samp_base;
                        tap_d   = '0;
                    end
                end
            end
            ISSUE: begin
                if (tap_q == len_q - 1'b1) begin
                    state_d = DRAIN;
                    tap_d   = '0;
                end else begin
                    tap_d = tap_q + 1'b1;
                end
            end
            DRAIN: begin
                if (tap_q == DRAIN_LAST) begin
                    state_d  = FINISH;
                    tap_d    = '0;
                    result_d = mac_p;
                end else begin
                    tap_d = tap_q + 1'b1;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign issue      = (state_q == ISSUE);
    assign tap0       = issue && (tap_q == '0);
    assign coef_rd_en = issue;
    assign samp_rd_en = issue;
    assign coef_addr  = issue ? tap_q[ADDR_W-1:0] : '0;
    assign samp_addr  = issue ? (base_q - tap_q[ADDR_W-1:0]) : '0;
    assign busy       = (state_q == ISSUE) || (state_q == DRAIN);
    assign done       = (state_q == FINISH);
    assign result     = result_q;

    mac_valid_pipe #(.DEPTH(RD_LAT)) u_vld_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .in_i  (issue),
        .out_o (opnd_vld)
    );

    // Tag lines up with tap 0's product at the adder input, so the old sum is dropped there.
    mac_valid_pipe #(.DEPTH(RD_LAT + MUL_LAT)) u_first_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .in_i  (tap0),
        .out_o (first_tap)
    );

    assign mac_a = opnd_vld  ? coef_data : '0;
    assign mac_b = opnd_vld  ? samp_data : '0;
    assign mac_c = first_tap ? '0 : mac_p;

endmodule

// File: doc/mac_tap_sequencer.md
Name: mac_tap_sequencer

Overview:
- Sequences one multiply-accumulate datapath (55x16 multiplier feeding a registered 78-bit adder, p <= c + a*b) through an N-tap dot product, for FIR/filter kernels in the voice pipeline.
- Reads coefficients in ascending address order and samples from a circular delay line in descending order, and streams both into the multiplier.
- Generates the adder's c operand: 0 for the first product, fed-back p for every later product.
- Returns the 78-bit sum with a done pulse. Sits between the coefficient/sample RAMs and the mul_add instance.

Parameters:
- ADDR_W, 10, address width of coefficient and sample RAMs.
- RD_LAT, 1, RAM read latency in cycles (rd_en/addr in cycle t, data valid in cycle t+RD_LAT).
- MUL_LAT, 3, multiplier pipeline latency (a/b in cycle x, product at adder input in cycle x+MUL_LAT).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  begin a job; sampled only in IDLE.
- len  in  ADDR_W+1  tap count, 0..2^ADDR_W.
- samp_base  in  ADDR_W  newest-sample address in the delay line.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse; result valid.
- result  out  78  accumulated sum, held until the next done.
- coef_rd_en  out  1  coefficient RAM read enable.
- coef_addr  out  ADDR_W  coefficient address.
- coef_data  in  55  coefficient read data.
- samp_rd_en  out  1  sample RAM read enable.
- samp_addr  out  ADDR_W  sample address.
- samp_data  in  16  sample read data.
- mac_a  out  55  to the multiplier a input.
- mac_b  out  16  to the multiplier b input.
- mac_c  out  78  to the adder c input.
- mac_p  in  78  registered adder output p.

Behaviour:
- Reset (rst_n low at a clock edge):
  - state returns to IDLE; busy, done, coef_rd_en and samp_rd_en go to 0; result, addresses, mac_a and mac_b go to 0.
  - All valid/first-tag pipeline stages clear.
  - Reset mid-job discards in-flight products; no done is produced.
- IDLE:
  - start=1 with len>=1: latch len and samp_base, go to ISSUE.
  - start=1 with len=0: go to FINISH directly; result becomes 0; no RAM reads.
- ISSUE (exactly len cycles):
  - coef_rd_en = samp_rd_en = 1.
  - Tap i (i=0..len-1): coef_addr = i; samp_addr = (samp_base - i) mod 2^ADDR_W, wrapping from 0 to 2^ADDR_W-1.
  - After the last tap, go to DRAIN.
- DRAIN: hold for RD_LAT+MUL_LAT+1 cycles, then go to FINISH.
- FINISH (one cycle): done=1; result is registered from mac_p on entry to this state; next state is IDLE.
- Operand gating:
  - A valid bit is delayed RD_LAT cycles from the rd_en cycle.
  - mac_a = valid ? coef_data : 0; mac_b = valid ? samp_data : 0. Products are therefore 0 outside a job.
- Accumulate control:
  - A first-tap tag is delayed RD_LAT+MUL_LAT cycles from the tap-0 rd_en cycle.
  - mac_c = tag ? 0 : mac_p, combinational. This clears any previous job's sum with no bubble.
- Latency:
  - start accepted in cycle k: taps are issued in cycles k+1..k+len.
  - done is high in cycle k+len+RD_LAT+MUL_LAT+2 (k+len+6 with defaults).
  - len=0: done in cycle k+1.
- Arithmetic:
  - Operands are raw unsigned bits; the block applies no sign handling.
  - The sum wraps modulo 2^78; there is no saturation.
- Concurrency:
  - start while busy is ignored.
  - start in the FINISH cycle is ignored.
  - start in the cycle after done is accepted, giving back-to-back jobs with a 1-cycle gap.
- busy is low in IDLE and FINISH.

Decomposition:
- Shared package holds:
  - MAC_A_W=55, MAC_B_W=16, MAC_P_W=78;
  - state enum IDLE/ISSUE/DRAIN/FINISH;
  - default latencies RD_LAT=1, MUL_LAT=3.
- One natural sub-module, mac_valid_pipe: parameterised shift register carrying the valid bit and the first-tap tag.
- The bench instantiates mac_tap_sequencer with the real mul_add and RAM models.

Test Plan:
- len=3, coef[0..2]={1,2,3}, samp_base=5, samp[5,4,3]={10,20,30} -> samp_addr sequence 5,4,3; done at k+9; result=140.
- samp_base=1, len=4, ADDR_W=10 -> samp_addr sequence 1,0,1023,1022; coef_addr sequence 0,1,2,3.
- Two back-to-back jobs, second started the cycle after the first done, first result 140, second all-ones coefficients x samples 1 over 2 taps -> second result=2, showing the first-tap c=0 clear.
- start with len=0 -> done at k+1, result=0, rd_en never asserted.
- rst_n low for 1 cycle during DRAIN -> no done; outputs zero; a following len=1 job with 7x9 gives result=63.
- coef=2^55-1, samp=2^16-1, len=8 -> result = 8*(2^55-1)*(2^16-1) mod 2^78 exactly; start pulses while busy have no effect.
